regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file, successor to the 8×16 single-read-port datapath register file. One synchronous write port, two asynchronous read ports (A and B, feeding the two ALU operand paths), and a per-register busy scoreboard. The controller uses the scoreboard to reserve a destination register at issue and to stall operand reads until the pending write lands. Sits in the datapath between the writeback mux and the A/B operand registers.

## Interface
Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers; power of two, at least 2; address width AW = $clog2(DEPTH)

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high
- data_in  input  WIDTH  write data
- writenum  input  AW  write address
- write  input  1  write enable
- readnum_a  input  AW  read port A address
- readnum_b  input  AW  read port B address
- data_out_a  output  WIDTH  read port A data, combinational
- data_out_b  output  WIDTH  read port B data, combinational
- busy_a  output  1  register at readnum_a has a pending write
- busy_b  output  1  register at readnum_b has a pending write
- reserve  input  1  request to mark reservenum busy
- reservenum  input  AW  register to reserve
- reserve_ok  output  1  combinational; reserve request accepted this cycle
- busy_vec  output  DEPTH  full scoreboard, bit i = register i busy

## Operation
- Storage: DEPTH registers of WIDTH bits, plus DEPTH busy bits.
- Reset: when reset=1 at a rising edge, all registers become 0 and all busy bits become 0. reset overrides write and reserve in the same cycle. After reset: data_out_a = data_out_b = 0, busy_a = busy_b = 0, busy_vec = 0, reserve_ok = reserve.
- Write: when write=1 at a rising edge, reg[writenum] <= data_in and busy[writenum] <= 0.
- Writing a register that is not busy is legal. It writes the data, and the busy bit stays 0.
- Reserve acceptance: reserve_ok = reserve & (~busy[reservenum] | (write & writenum==reservenum)).
- Reserve: when reserve_ok=1 at a rising edge, busy[reservenum] <= 1.
- A rejected reserve changes nothing, and the requester retries.
- Simultaneous write and accepted reserve to the same register: the data is written and the busy bit ends at 1 (the reserve wins, giving back-to-back reuse of a destination).
- Write and reserve to different registers in the same cycle are independent.
- Reads: data_out_x = reg[readnum_x] and busy_x = busy[readnum_x], both combinational from the current state. Ports A and B may address the same register.
- Write is a plain registered write; write to a register at any address is allowed, including the one being read (see Configuration for same-cycle visibility).

## Timing
- Write latency: data written at edge N is visible on the read ports immediately after edge N.
- Busy set latency: a reserve accepted at edge N makes busy visible after edge N.
- Busy clear latency: a write at edge N clears busy after edge N.
- reserve_ok and the read outputs depend only on current inputs and state. There is no registered output stage.
- Reset asserted mid-sequence (with reservations outstanding) clears everything at that edge. The write and reserve presented in that cycle are discarded.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write forwarding.
  - When write=1 and writenum==readnum_x, data_out_x = data_in and busy_x = 0 in that cycle.
  - This applies to each port independently.
  - Forwarding is suppressed while reset=1.
- REGFILE_BYPASS_EN undefined: reads always return stored state. The new value and the busy clear appear only after the edge.
- busy_vec, reserve_ok and the storage behaviour are identical in both builds.

## Test plan
- Reset then basic write/read: after reset, all reads return 0 and busy_vec=0. Write 0x0042→R0 and 0x0023→R1, then readnum_a=0 and readnum_b=1 → data_out_a=0x0042, data_out_b=0x0023.
- Dual-port same address: write 0xFFFF→R5, then readnum_a=readnum_b=5 → both ports return 0xFFFF. Write 0x0042→R5 → both ports return 0x0042 after the edge.
- Scoreboard: reserve R3 → busy_vec=0x08, and readnum_a=3 gives busy_a=1. A second reserve of R3 gives reserve_ok=0 and busy is unchanged. Write 0x0092→R3 → busy_vec=0x00 and data_out_a=0x0092.
- Simultaneous events:
  - With R2 busy, write 0x00F1→R2 together with reserve R2 → reserve_ok=1, and after the edge R2=0x00F1 with busy_vec bit2=1.
  - Write R7 together with reserve R6 → R7 is written, bit7=0 and bit6=1.
- Bypass: write=1, writenum=4, data_in=0x0012, readnum_a=4, with R4 holding 0x0000 and busy. Before the edge:
  - With REGFILE_BYPASS_EN: data_out_a=0x0012, busy_a=0.
  - Without it: 0x0000 and busy_a=1.
  - Both builds read 0x0012 after the edge.
- Reset mid-operation: with R1 and R3 reserved and R1=0x0023, assert reset together with write 0xEEEE→R1 → after the edge, all registers are 0 and busy_vec=0. Parameter sweep WIDTH=32, DEPTH=16: write 0xDEADBEEF→R15 and read it back on both ports.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with one synchronous write port, two asynchronous read ports and a busy scoreboard.
// Optional same-cycle write forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic [AW-1:0]    writenum,
   input  logic             write,
   input  logic [AW-1:0]    readnum_a,
   input  logic [AW-1:0]    readnum_b,
   output logic [WIDTH-1:0] data_out_a,
   output logic [WIDTH-1:0] data_out_b,
   output logic             busy_a,
   output logic             busy_b,
   input  logic             reserve,
   input  logic [AW-1:0]    reservenum,
   output logic             reserve_ok,
   output logic [DEPTH-1:0] busy_vec
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("regfile_mp: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;

   // A write landing on the register being reserved frees it in the same cycle.
   always_comb begin
      reserve_ok = reserve & (~busy[reservenum] | (write & (writenum == reservenum)));
   end

   // Write clears first, accepted reserve sets last, so a same-register reserve wins.
   always_comb begin
      busy_next = busy;
      if (write) begin
         busy_next[writenum] = 1'b0;
      end
      if (reserve_ok) begin
         busy_next[reservenum] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (write) begin
            regs[writenum] <= data_in;
         end
         busy <= busy_next;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_a;
   logic fwd_b;

   always_comb begin
      fwd_a      = write & ~reset & (writenum == readnum_a);
      fwd_b      = write & ~reset & (writenum == readnum_b);
      data_out_a = fwd_a ? data_in : regs[readnum_a];
      data_out_b = fwd_b ? data_in : regs[readnum_b];
      busy_a     = ~fwd_a & busy[readnum_a];
      busy_b     = ~fwd_b & busy[readnum_b];
   end
`else
   always_comb begin
      data_out_a = regs[readnum_a];
      data_out_b = regs[readnum_b];
      busy_a     = busy[readnum_a];
      busy_b     = busy[readnum_b];
   end
`endif

   assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array-based reference model compared every cycle, plus directed literal checks.
// Covers the default 16x8 configuration and a 32x16 instance.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] data_in = '0;
   logic [2:0]  writenum = '0;
   logic        write = 1'b0;
   logic [2:0]  readnum_a = '0;
   logic [2:0]  readnum_b = '0;
   logic [15:0] data_out_a;
   logic [15:0] data_out_b;
   logic        busy_a;
   logic        busy_b;
   logic        reserve = 1'b0;
   logic [2:0]  reservenum = '0;
   logic        reserve_ok;
   logic [7:0]  busy_vec;

   logic        reset2 = 1'b0;
   logic [31:0] data_in2 = '0;
   logic [3:0]  writenum2 = '0;
   logic        write2 = 1'b0;
   logic [3:0]  readnum_a2 = '0;
   logic [3:0]  readnum_b2 = '0;
   logic [31:0] data_out_a2;
   logic [31:0] data_out_b2;
   logic        busy_a2;
   logic        busy_b2;
   logic        reserve2 = 1'b0;
   logic [3:0]  reservenum2 = '0;
   logic        reserve_ok2;
   logic [15:0] busy_vec2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
      .readnum_a(readnum_a), .readnum_b(readnum_b), .data_out_a(data_out_a), .data_out_b(data_out_b),
      .busy_a(busy_a), .busy_b(busy_b), .reserve(reserve), .reservenum(reservenum),
      .reserve_ok(reserve_ok), .busy_vec(busy_vec)
   );

   regfile_mp #(.WIDTH(32), .DEPTH(16)) dut2 (
      .clk(clk), .reset(reset2), .data_in(data_in2), .writenum(writenum2), .write(write2),
      .readnum_a(readnum_a2), .readnum_b(readnum_b2), .data_out_a(data_out_a2), .data_out_b(data_out_b2),
      .busy_a(busy_a2), .busy_b(busy_b2), .reserve(reserve2), .reservenum(reservenum2),
      .reserve_ok(reserve_ok2), .busy_vec(busy_vec2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain arrays updated by the rules of the register file.
   logic [15:0] m_mem [8];
   bit          m_busy [8];
   bit          model_valid = 0;

   always @(posedge clk) begin
      bit ok;
      ok = reserve && (!m_busy[reservenum] || (write && writenum == reservenum));
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 0;
         end
         model_valid = 1;
      end else begin
         if (write) begin
            m_mem[writenum] = data_in;
            m_busy[writenum] = 0;
         end
         if (ok) m_busy[reservenum] = 1;
      end
   end

   always @(negedge clk) begin
      logic [15:0] ea, eb;
      logic        eba, ebb, eok;
      logic [7:0]  ev;
      if (model_valid) begin
         ea = m_mem[readnum_a];
         eb = m_mem[readnum_b];
         eba = m_busy[readnum_a];
         ebb = m_busy[readnum_b];
`ifdef REGFILE_BYPASS_EN
         if (write && !reset && writenum == readnum_a) begin
            ea = data_in;
            eba = 1'b0;
         end
         if (write && !reset && writenum == readnum_b) begin
            eb = data_in;
            ebb = 1'b0;
         end
`endif
         eok = reserve && (!m_busy[reservenum] || (write && writenum == reservenum));
         for (int i = 0; i < 8; i++) ev[i] = m_busy[i];
         check("model_data_a", 64'(data_out_a), 64'(ea));
         check("model_data_b", 64'(data_out_b), 64'(eb));
         check("model_busy_a", 64'(busy_a), 64'(eba));
         check("model_busy_b", 64'(busy_b), 64'(ebb));
         check("model_reserve_ok", 64'(reserve_ok), 64'(eok));
         check("model_busy_vec", 64'(busy_vec), 64'(ev));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0;
      write = 1'b0;
      reserve = 1'b0;
      #1;
   endtask

   initial begin
      // reset both instances
      reset = 1'b1;
      reset2 = 1'b1;
      step();
      reset2 = 1'b0;
      idle();
      check("reset_data_a", 64'(data_out_a), 64'h0);
      check("reset_data_b", 64'(data_out_b), 64'h0);
      check("reset_busy_vec", 64'(busy_vec), 64'h0);
      check("reset_busy_a", 64'(busy_a), 64'h0);
      check("reset_ok_idle", 64'(reserve_ok), 64'h0);
      reserve = 1'b1; reservenum = 3'd0; #1;
      check("reset_ok_req", 64'(reserve_ok), 64'h1);
      idle();

      // basic write / read
      write = 1'b1; writenum = 3'd0; data_in = 16'h0042; step();
      writenum = 3'd1; data_in = 16'h0023; step();
      idle();
      readnum_a = 3'd0; readnum_b = 3'd1; #1;
      check("basic_a", 64'(data_out_a), 64'h0042);
      check("basic_b", 64'(data_out_b), 64'h0023);

      // dual port same address
      write = 1'b1; writenum = 3'd5; data_in = 16'hFFFF; step();
      idle();
      readnum_a = 3'd5; readnum_b = 3'd5; #1;
      check("same_addr_a", 64'(data_out_a), 64'hFFFF);
      check("same_addr_b", 64'(data_out_b), 64'hFFFF);
      write = 1'b1; writenum = 3'd5; data_in = 16'h0042; step();
      idle();
      check("same_addr_a2", 64'(data_out_a), 64'h0042);
      check("same_addr_b2", 64'(data_out_b), 64'h0042);

      // scoreboard
      reserve = 1'b1; reservenum = 3'd3; #1;
      check("rsv3_ok", 64'(reserve_ok), 64'h1);
      step();
      reserve = 1'b0; readnum_a = 3'd3; #1;
      check("rsv3_vec", 64'(busy_vec), 64'h08);
      check("rsv3_busy_a", 64'(busy_a), 64'h1);
      reserve = 1'b1; reservenum = 3'd3; #1;
      check("rsv3_again_ok", 64'(reserve_ok), 64'h0);
      step();
      reserve = 1'b0; #1;
      check("rsv3_again_vec", 64'(busy_vec), 64'h08);
      write = 1'b1; writenum = 3'd3; data_in = 16'h0092; step();
      idle();
      check("wr3_vec", 64'(busy_vec), 64'h00);
      check("wr3_data", 64'(data_out_a), 64'h0092);

      // simultaneous write + reserve to the same register
      reserve = 1'b1; reservenum = 3'd2; step();
      write = 1'b1; writenum = 3'd2; data_in = 16'h00F1; #1;
      check("wr_rsv_same_ok", 64'(reserve_ok), 64'h1);
      step();
      idle();
      readnum_a = 3'd2; #1;
      check("wr_rsv_same_data", 64'(data_out_a), 64'h00F1);
      check("wr_rsv_same_vec", 64'(busy_vec), 64'h04);

      // write R7 with reserve R6
      write = 1'b1; writenum = 3'd7; data_in = 16'h0077;
      reserve = 1'b1; reservenum = 3'd6; step();
      idle();
      readnum_a = 3'd7; readnum_b = 3'd2; #1;
      check("wr7_rsv6_vec", 64'(busy_vec), 64'h44);
      check("wr7_data", 64'(data_out_a), 64'h0077);
      check("wr7_r2_data", 64'(data_out_b), 64'h00F1);

      // forwarding boundary on a busy, zero-valued register
      reserve = 1'b1; reservenum = 3'd4; step();
      reserve = 1'b0;
      write = 1'b1; writenum = 3'd4; data_in = 16'h0012; readnum_a = 3'd4; #1;
`ifdef REGFILE_BYPASS_EN
      check("bypass_pre_data", 64'(data_out_a), 64'h0012);
      check("bypass_pre_busy", 64'(busy_a), 64'h0);
`else
      check("bypass_pre_data", 64'(data_out_a), 64'h0000);
      check("bypass_pre_busy", 64'(busy_a), 64'h1);
`endif
      step();
      idle();
      check("bypass_post_data", 64'(data_out_a), 64'h0012);
      check("bypass_post_busy", 64'(busy_a), 64'h0);

      // reset with reservations outstanding
      reserve = 1'b1; reservenum = 3'd1; step();
      reservenum = 3'd3; step();
      idle();
      readnum_a = 3'd1; #1;
      check("pre_reset_vec", 64'(busy_vec), 64'h4E);
      check("pre_reset_r1", 64'(data_out_a), 64'h0023);
      reset = 1'b1; write = 1'b1; writenum = 3'd1; data_in = 16'hEEEE;
      reserve = 1'b1; reservenum = 3'd5; #1;
      check("reset_no_fwd", 64'(data_out_a), 64'h0023);
      step();
      idle();
      check("mid_reset_vec", 64'(busy_vec), 64'h00);
      for (int i = 0; i < 8; i++) begin
         readnum_a = 3'(i); readnum_b = 3'(7 - i); #1;
         check("mid_reset_a", 64'(data_out_a), 64'h0);
         check("mid_reset_b", 64'(data_out_b), 64'h0);
      end

      // 32x16 instance
      write2 = 1'b1; writenum2 = 4'd15; data_in2 = 32'hDEADBEEF; step();
      write2 = 1'b0; readnum_a2 = 4'd15; readnum_b2 = 4'd15; #1;
      check("wide_a", 64'(data_out_a2), 64'hDEADBEEF);
      check("wide_b", 64'(data_out_b2), 64'hDEADBEEF);
      check("wide_vec", 64'(busy_vec2), 64'h0);
      reserve2 = 1'b1; reservenum2 = 4'd15; step();
      reserve2 = 1'b0; #1;
      check("wide_rsv_vec", 64'(busy_vec2), 64'h8000);
      check("wide_rsv_busy_b", 64'(busy_b2), 64'h1);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
